// File: rtl/inst_decode_pipe_if.sv
// Handshake bundle for inst_decode_pipe: raw instruction words in, decoded words out.
interface inst_decode_pipe_if #(
    parameter int OPW     = 2,
    parameter int ARGW    = 6,
    parameter int NUM_OPS = 4
);
    logic                 in_valid;
    logic                 in_ready;
    logic [OPW+ARGW-1:0]  in_inst;
    logic                 out_valid;
    logic                 out_ready;
    logic [NUM_OPS-1:0]   out_onehot;
    logic [ARGW-1:0]      out_arg;
    logic                 out_illegal;

    modport master (
        output in_valid, in_inst, out_ready,
        input  in_ready, out_valid, out_onehot, out_arg, out_illegal
    );

    modport slave (
        input  in_valid, in_inst, out_ready,
        output in_ready, out_valid, out_onehot, out_arg, out_illegal
    );
endinterface

// File: rtl/inst_decode_pipe.sv
// Pipelined one-hot instruction decoder with a 2-entry skid buffer.
// Optional per-opcode retire counters are built when INST_DECODE_CNT_EN is defined.
module inst_decode_pipe #(
    parameter int OPW     = 2,
    parameter int ARGW    = 6,
    parameter int NUM_OPS = 4,
    parameter int CNTW    = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    inst_decode_pipe_if.slave   bus,
    input  logic                clr_cnt,
    input  logic [OPW-1:0]      cnt_sel,
    output logic [CNTW-1:0]     cnt_value
);

    typedef struct packed {
        logic [NUM_OPS-1:0] onehot;
        logic [ARGW-1:0]    arg;
        logic               illegal;
    } entry_t;

    logic [OPW-1:0] dec_op;
    entry_t         dec;
    entry_t         m_q, m_d, s_q, s_d;
    logic           m_valid_q, m_valid_d;
    logic           s_valid_q, s_valid_d;
    logic           in_ready_q, in_ready_d;
    logic           acc, drn;

    assign dec_op = bus.in_inst[OPW-1:0];

    always_comb begin
        dec.onehot = '0;
        for (int k = 0; k < NUM_OPS; k++) begin
            dec.onehot[k] = (32'(dec_op) == k);
        end
        dec.arg     = bus.in_inst[OPW+ARGW-1:OPW];
        dec.illegal = (32'(dec_op) >= NUM_OPS);
    end

    assign acc = bus.in_valid && in_ready_q;
    assign drn = m_valid_q && bus.out_ready;

    // m_valid/s_valid encode EMPTY (0,0), ONE (1,0), FULL (1,1)
    always_comb begin
        m_d       = m_q;
        s_d       = s_q;
        m_valid_d = m_valid_q;
        s_valid_d = s_valid_q;
        if (!m_valid_q) begin
            if (acc) begin
                m_d       = dec;
                m_valid_d = 1'b1;
            end
        end else if (!s_valid_q) begin
            if (acc && drn) begin
                m_d = dec;
            end else if (acc) begin
                s_d       = dec;
                s_valid_d = 1'b1;
            end else if (drn) begin
                m_valid_d = 1'b0;
            end
        end else if (drn) begin
            m_d       = s_q;
            s_valid_d = 1'b0;
        end
        in_ready_d = !s_valid_d;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            m_q        <= '0;
            s_q        <= '0;
            m_valid_q  <= 1'b0;
            s_valid_q  <= 1'b0;
            in_ready_q <= 1'b1;
        end else begin
            m_q        <= m_d;
            s_q        <= s_d;
            m_valid_q  <= m_valid_d;
            s_valid_q  <= s_valid_d;
            in_ready_q <= in_ready_d;
        end
    end

    assign bus.in_ready    = in_ready_q;
    assign bus.out_valid   = m_valid_q;
    assign bus.out_onehot  = m_q.onehot;
    assign bus.out_arg     = m_q.arg;
    assign bus.out_illegal = m_q.illegal;

`ifdef INST_DECODE_CNT_EN
    // Index NUM_OPS is the illegal-opcode counter
    logic [CNTW-1:0] cnt_q [NUM_OPS+1];
    logic [CNTW-1:0] cnt_d [NUM_OPS+1];

    always_comb begin
        for (int k = 0; k < NUM_OPS; k++) begin
            cnt_d[k] = cnt_q[k];
            if (clr_cnt) begin
                cnt_d[k] = '0;
            end else if (drn && m_q.onehot[k] && (cnt_q[k] != '1)) begin
                cnt_d[k] = cnt_q[k] + CNTW'(1);
            end
        end
        cnt_d[NUM_OPS] = cnt_q[NUM_OPS];
        if (clr_cnt) begin
            cnt_d[NUM_OPS] = '0;
        end else if (drn && m_q.illegal && (cnt_q[NUM_OPS] != '1)) begin
            cnt_d[NUM_OPS] = cnt_q[NUM_OPS] + CNTW'(1);
        end
    end

    always_ff @(posedge clk) begin
        for (int k = 0; k <= NUM_OPS; k++) begin
            if (!rst_n) begin
                cnt_q[k] <= '0;
            end else begin
                cnt_q[k] <= cnt_d[k];
            end
        end
    end

    always_comb begin
        cnt_value = cnt_q[NUM_OPS];
        for (int k = 0; k < NUM_OPS; k++) begin
            if (32'(cnt_sel) == k) begin
                cnt_value = cnt_q[k];
            end
        end
    end
`else
    logic unused_cnt_in;

    assign unused_cnt_in = ^{clr_cnt, cnt_sel};
    assign cnt_value     = '0;
`endif

endmodule

// File: tb/tb_inst_decode_pipe.sv
// Directed bench: a 4-opcode/16-bit-counter decoder and a 3-opcode/2-bit-counter decoder share one stimulus.
module tb_inst_decode_pipe;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [7:0]  in_inst;
    logic        out_ready;
    logic        clr_cnt;
    logic [1:0]  cnt_sel;
    logic [15:0] cnt_value_a;
    logic [1:0]  cnt_value_b;

    int n_tests;
    int n_fail;

    inst_decode_pipe_if #(.OPW(2), .ARGW(6), .NUM_OPS(4)) ifa ();
    inst_decode_pipe_if #(.OPW(2), .ARGW(6), .NUM_OPS(3)) ifb ();

    assign ifa.in_valid  = in_valid;
    assign ifa.in_inst   = in_inst;
    assign ifa.out_ready = out_ready;
    assign ifb.in_valid  = in_valid;
    assign ifb.in_inst   = in_inst;
    assign ifb.out_ready = out_ready;

    inst_decode_pipe #(.OPW(2), .ARGW(6), .NUM_OPS(4), .CNTW(16)) dut_a (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (ifa.slave),
        .clr_cnt   (clr_cnt),
        .cnt_sel   (cnt_sel),
        .cnt_value (cnt_value_a)
    );

    inst_decode_pipe #(.OPW(2), .ARGW(6), .NUM_OPS(3), .CNTW(2)) dut_b (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (ifb.slave),
        .clr_cnt   (clr_cnt),
        .cnt_sel   (cnt_sel),
        .cnt_value (cnt_value_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       v;
        logic [7:0] inst;
        logic       rdy;
        logic       e_ir;
        logic       e_ov;
        logic [3:0] e_oh;
        logic [5:0] e_arg;
    } vec_t;

    vec_t tbl [12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_cnt(input string name, input logic [1:0] sel,
                           input logic [15:0] exp_a, input logic [1:0] exp_b);
        cnt_sel = sel;
        #1;
`ifdef INST_DECODE_CNT_EN
        chk({name, "_a"}, 32'(cnt_value_a), 32'(exp_a));
        chk({name, "_b"}, 32'(cnt_value_b), 32'(exp_b));
`else
        chk({name, "_a_off"}, 32'(cnt_value_a), 32'd0);
        chk({name, "_b_off"}, 32'(cnt_value_b), 32'd0);
`endif
    endtask

    initial begin
        logic [15:0] ea [4];
        n_tests   = 0;
        n_fail    = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_inst   = 8'h00;
        out_ready = 1'b0;
        clr_cnt   = 1'b0;
        cnt_sel   = 2'd0;

        // inst = {arg, op}
        tbl[0]  = '{1'b1, 8'h14, 1'b1, 1'b1, 1'b1, 4'b0001, 6'h05};
        tbl[1]  = '{1'b1, 8'h29, 1'b1, 1'b1, 1'b1, 4'b0010, 6'h0A};
        tbl[2]  = '{1'b1, 8'h56, 1'b1, 1'b1, 1'b1, 4'b0100, 6'h15};
        tbl[3]  = '{1'b1, 8'hFF, 1'b1, 1'b1, 1'b1, 4'b1000, 6'h3F};
        tbl[4]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 4'b0000, 6'h00};
        tbl[5]  = '{1'b1, 8'h05, 1'b0, 1'b1, 1'b1, 4'b0010, 6'h01};
        tbl[6]  = '{1'b1, 8'h0A, 1'b0, 1'b0, 1'b1, 4'b0010, 6'h01};
        tbl[7]  = '{1'b1, 8'h0F, 1'b0, 1'b0, 1'b1, 4'b0010, 6'h01};
        tbl[8]  = '{1'b1, 8'h0F, 1'b0, 1'b0, 1'b1, 4'b0010, 6'h01};
        tbl[9]  = '{1'b1, 8'h0F, 1'b1, 1'b1, 1'b1, 4'b0100, 6'h02};
        tbl[10] = '{1'b1, 8'h0F, 1'b1, 1'b1, 1'b1, 4'b1000, 6'h03};
        tbl[11] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 4'b0000, 6'h00};

        tick();
        tick();
        chk("rst_out_valid", 32'(ifa.out_valid), 32'd0);
        chk("rst_in_ready", 32'(ifa.in_ready), 32'd1);
        chk("rst_onehot", 32'(ifa.out_onehot), 32'd0);
        chk("rst_arg", 32'(ifa.out_arg), 32'd0);
        chk("rst_illegal", 32'(ifb.out_illegal), 32'd0);
        chk_cnt("rst_cnt0", 2'd0, 16'd0, 2'd0);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 12; i++) begin
            in_valid  = tbl[i].v;
            in_inst   = tbl[i].inst;
            out_ready = tbl[i].rdy;
            tick();
            chk($sformatf("v%0d_in_ready", i), 32'(ifa.in_ready), 32'(tbl[i].e_ir));
            chk($sformatf("v%0d_out_valid", i), 32'(ifa.out_valid), 32'(tbl[i].e_ov));
            chk($sformatf("v%0d_b_in_ready", i), 32'(ifb.in_ready), 32'(tbl[i].e_ir));
            chk($sformatf("v%0d_b_out_valid", i), 32'(ifb.out_valid), 32'(tbl[i].e_ov));
            if (tbl[i].e_ov) begin
                chk($sformatf("v%0d_onehot", i), 32'(ifa.out_onehot), 32'(tbl[i].e_oh));
                chk($sformatf("v%0d_arg", i), 32'(ifa.out_arg), 32'(tbl[i].e_arg));
                chk($sformatf("v%0d_illegal", i), 32'(ifa.out_illegal), 32'd0);
                // opcode 3 is illegal in the 3-opcode build
                chk($sformatf("v%0d_b_onehot", i), 32'(ifb.out_onehot), 32'(tbl[i].e_oh[2:0]));
                chk($sformatf("v%0d_b_arg", i), 32'(ifb.out_arg), 32'(tbl[i].e_arg));
                chk($sformatf("v%0d_b_illegal", i), 32'(ifb.out_illegal), 32'(tbl[i].e_oh[3]));
            end
        end

        ea[0] = 16'd1; ea[1] = 16'd2; ea[2] = 16'd2; ea[3] = 16'd2;
        for (int s = 0; s < 4; s++) begin
            chk_cnt($sformatf("cnt_sel%0d", s), 2'(s), ea[s], ea[s][1:0]);
        end

        // Fill to FULL, then reset with a handshake offered on the same edge
        in_valid  = 1'b1;
        out_ready = 1'b0;
        in_inst   = 8'h05;
        tick();
        in_inst   = 8'h0A;
        tick();
        chk("full_in_ready", 32'(ifa.in_ready), 32'd0);
        rst_n     = 1'b0;
        out_ready = 1'b1;
        in_inst   = 8'h0F;
        tick();
        chk("rstfull_out_valid", 32'(ifa.out_valid), 32'd0);
        chk("rstfull_in_ready", 32'(ifa.in_ready), 32'd1);
        chk("rstfull_onehot", 32'(ifa.out_onehot), 32'd0);
        chk("rstfull_arg", 32'(ifa.out_arg), 32'd0);
        chk("rstfull_b_illegal", 32'(ifb.out_illegal), 32'd0);
        for (int s = 0; s < 4; s++) begin
            chk_cnt($sformatf("rstfull_cnt%0d", s), 2'(s), 16'd0, 2'd0);
        end
        rst_n    = 1'b1;
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("post_rst_out_valid%0d", i), 32'(ifa.out_valid), 32'd0);
        end

        // Five XOR retires: saturates the 2-bit counter
        in_valid  = 1'b1;
        in_inst   = 8'h00;
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        in_valid = 1'b0;
        tick();
        chk_cnt("sat_xor", 2'd0, 16'd5, 2'd3);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        clr_cnt  = 1'b1;
        tick();
        clr_cnt  = 1'b0;
        chk("clr_drained", 32'(ifa.out_valid), 32'd0);
        chk_cnt("clr_wins", 2'd0, 16'd0, 2'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/inst_decode_pipe.md
# inst_decode_pipe

Parametrised, pipelined instruction decoder for the bitxor core. It accepts raw instruction words over a valid/ready handshake and splits each word into an opcode field and an operand field. It emits a registered one-hot opcode vector, the operand and an illegal-opcode flag through a 2-entry skid buffer, so both `in_ready` and all outputs are registered. It sits between instruction fetch and the execute unit. It replaces the per-opcode combinational decoders for XOR/OUT/SETL/SETR and adds illegal-opcode detection and optional per-opcode retire counters.

## Interface
- `OPW`, 2, opcode field width in bits.
- `ARGW`, 6, operand field width in bits; must be ≥1.
- `NUM_OPS`, 4, number of legal opcodes; 1 ≤ NUM_OPS ≤ 2^OPW.
- `CNTW`, 16, retire counter width.

- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  reset; synchronous, active-low.
- `in_valid`  in  1  upstream word valid.
- `in_ready`  out  1  decoder can accept a word; registered.
- `in_inst`  in  OPW+ARGW  instruction word: opcode = `[OPW-1:0]`, operand = `[OPW+ARGW-1:OPW]`.
- `out_valid`  out  1  decoded word valid.
- `out_ready`  in  1  downstream accepts the decoded word.
- `out_onehot`  out  NUM_OPS  bit k = 1 iff opcode == k.
- `out_arg`  out  ARGW  operand field, passed through unchanged.
- `out_illegal`  out  1  opcode ≥ NUM_OPS; `out_onehot` is all zero in this case.
- `clr_cnt`  in  1  synchronous clear of all retire counters.
- `cnt_sel`  in  OPW  counter select; any value ≥ NUM_OPS selects the illegal counter.
- `cnt_value`  out  CNTW  selected counter value; combinational read of registers.

## Operation
- Opcode map at default `OPW`/`NUM_OPS`:
  - 0 = XOR
  - 1 = OUT
  - 2 = SETL
  - 3 = SETR
- Decode is combinational on `in_inst`. The result is captured into the main register (M) or the skid register (S) on input acceptance, defined as `in_valid && in_ready`.
- Storage states:
  - EMPTY: M invalid, S invalid.
  - ONE: M valid, S invalid.
  - FULL: M valid, S valid.
- Outputs and `in_ready`:
  - `out_valid` = M valid.
  - `in_ready` = 1 in EMPTY and ONE; 0 in FULL.
- Transitions (acc = input accept, drn = `out_valid && out_ready`):
  - EMPTY, acc → ONE; the new word goes to M.
  - ONE, acc & drn → ONE; M ← new word.
  - ONE, acc & !drn → FULL; S ← new word.
  - ONE, !acc & drn → EMPTY.
  - FULL, drn → ONE; M ← S. No accept is possible because `in_ready` = 0.
  - Any other combination holds state.
- While `out_valid && !out_ready`, `out_onehot`, `out_arg` and `out_illegal` are held stable.
- Ordering is strictly FIFO. No word is dropped or duplicated.
- Retire counters:
  - There are NUM_OPS+1 counters: one per legal opcode, plus one illegal counter.
  - On drn, the counter for M's opcode (or the illegal counter) increments by 1 and saturates at 2^CNTW−1.
  - `clr_cnt` zeroes all counters. If `clr_cnt` and an increment occur in the same cycle, the clear wins and the result is 0.

## Timing
- Reset (`rst_n` = 0 at an edge):
  - State → EMPTY.
  - `out_valid` = 0, `in_ready` = 1.
  - `out_onehot` = 0, `out_arg` = 0, `out_illegal` = 0.
  - All counters = 0, so `cnt_value` = 0.
- Reset mid-operation discards both buffered words. A handshake on the same edge as reset is ignored.
- Latency: a word accepted at edge N is on the outputs with `out_valid` = 1 after edge N.
- Throughput: 1 word/cycle while `out_ready` = 1.
- After a stall begins with the block in ONE, exactly one more word is accepted before `in_ready` drops (entering FULL). `in_ready` returns to 1 on the edge after the first drn.
- `cnt_value` reflects a counter update one cycle after the drn or clear edge.

## Configuration
- `INST_DECODE_CNT_EN` defined: retire counters, `clr_cnt` and the `cnt_sel` read mux are built as specified.
- Not defined: no counter registers are built. `cnt_value` is tied to 0, and `clr_cnt`/`cnt_sel` are ignored. Decode and handshake behaviour are identical in both cases.

## Test plan
- Reset then stream opcodes 0,1,2,3 with args 0x05,0x0A,0x15,0x3F and `out_ready` = 1 → `out_onehot` 0001, 0010, 0100, 1000 with matching args, one per cycle, first output 1 cycle after first accept.
- `NUM_OPS` = 3: send opcode 3, arg 0x11 → `out_illegal` = 1, `out_onehot` = 000, `out_arg` = 0x11. Read `cnt_sel` = 3 → 1.
- Hold `out_ready` = 0 and offer 3 words → 2 accepted, `in_ready` = 0 in FULL, outputs stable. Raise `out_ready` → words emerge in order, `in_ready` = 1 after the first drain.
- With `CNTW` = 2, retire 5 XORs → `cnt_sel` = 0 reads 3 (saturated). Assert `clr_cnt` in the same cycle as a sixth retire → reads 0.
- Assert `rst_n` = 0 while FULL → next cycle `out_valid` = 0, `in_ready` = 1, counters 0. The buffered words never appear.
- Build without `INST_DECODE_CNT_EN`, stream 10 words → `cnt_value` stays 0 and decode outputs match the build with the macro defined.
